alu_uop_decoder: RTL
====================

# alu_uop_decoder

Parametrised, buffered successor to the single-cycle ALU control decode. It decodes the full RV32I register-register (OP) and register-immediate (OP-IMM) ALU instruction set: add/sub, logic, shifts and set-less-than. Results go into a DEPTH-entry decoded-uop FIFO with valid/ready handshakes on both sides. The block sits between the instruction decode stage and the execution-unit dispatch. It adds illegal-encoding detection, a flush, and a saturating illegal-instruction counter.

## Interface
Parameters:
- TAG_WIDTH, 4, width of the opaque instruction tag carried alongside each uop.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_WIDTH, 8, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; empties the FIFO.
- in_valid  in  1  an instruction is presented.
- in_ready  out  1  the block can accept an instruction this cycle.
- in_opcode  in  7  instruction[6:0].
- in_funct3  in  3  instruction[14:12].
- in_funct7  in  7  instruction[31:25].
- in_tag  in  TAG_WIDTH  passthrough tag.
- out_valid  out  1  the FIFO head is valid.
- out_ready  in  1  the consumer takes the head this cycle.
- out_ctrl_op  out  4  operation code: 0 NONE, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU.
- out_class  out  4  one-hot unit select: [0] adder (ADD/SUB), [1] logic, [2] shifter, [3] compare.
- out_is_imm  out  1  operand B is the immediate (OP-IMM).
- out_illegal  out  1  the encoding is not a legal ALU instruction.
- out_tag  out  TAG_WIDTH  the tag of the head entry.
- illegal_count  out  CNT_WIDTH  saturating count of accepted illegal instructions.

## Operation
- Decode is combinational on the in_* signals. The result is written into the FIFO on an accept, defined as in_valid && in_ready && !flush.
- OP (0110011), funct7 = 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- OP, funct7 = 0100000: funct3 000 SUB, 101 SRA. All other funct3 values are illegal.
- OP, any other funct7: illegal.
- OP-IMM (0010011): funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND, with funct7 ignored. out_is_imm = 1.
- OP-IMM shifts:
  - funct3 001 is SLL only when funct7 = 0000000.
  - funct3 101 is SRL when funct7 = 0000000 and SRA when funct7 = 0100000.
  - Any other funct7 on a shift is illegal.
- Any other opcode is illegal.
- An illegal entry carries ctrl_op = 0, class = 0, is_imm = 0 and illegal = 1. It is still queued so the pipeline can raise an exception with the correct tag.
- For legal entries, out_class is exactly one-hot and consistent with ctrl_op.
- FIFO uses read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- in_ready = (count != DEPTH). There is no full-bypass: while full, in_ready stays low even if out_ready is high.
- A pop occurs when out_valid && out_ready. Push and pop in the same cycle leave count unchanged.
- illegal_count increments by 1 on each accept with illegal = 1. It saturates at all-ones and is not cleared by flush.
- flush has priority: pointers and count go to 0, and the same-cycle push and pop are both discarded.
- Reset, asynchronous and active-low:
  - count, pointers and illegal_count go to 0.
  - out_valid = 0 and in_ready = 1.
  - out_ctrl_op, out_class, out_is_imm, out_illegal and out_tag read 0.
  - Asserting reset mid-operation discards all queued entries immediately.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible with out_valid = 1 after edge N, provided the FIFO was empty.
- The out_* fields are driven from the head entry registers, with no combinational path from in_* to out_*.
- out_* fields are qualified by out_valid. While the FIFO is empty the fields read 0.
- in_ready depends only on registered count; there is no combinational path from out_ready.
- Sustained throughput is 1 uop per cycle while out_ready is held high.
- Ordering is strictly FIFO. The tag returned equals the tag accepted.
- With out_ready low, exactly DEPTH accepts fill the FIFO. in_ready drops after the edge of the DEPTH-th accept.

## Test plan
- Reset with in_valid held high: after reset is deasserted, out_valid = 0, in_ready = 1, illegal_count = 0 and all out_* = 0. The first accept appears at the output 1 cycle later.
- Present all 10 OP encodings and all 9 OP-IMM encodings, with out_ready = 1. Each must produce the listed ctrl_op, a one-hot class and the correct is_imm, back-to-back at 1 per cycle.
- Illegal encodings:
  - inputs: OP funct3 = 000 with funct7 = 0000001; OP funct3 = 001 with funct7 = 0100000; OP-IMM funct3 = 001 with funct7 = 0100000; opcode 1100011.
  - required: each gives illegal = 1, ctrl_op = 0, and illegal_count ends at 4.
- DEPTH = 4 with out_ready = 0:
  - Four accepts with tags 1-4 drop in_ready.
  - A fifth in_valid is not accepted.
  - Raising out_ready returns tags 1, 2, 3, 4 in order.
  - Then issue 6 more pushes with simultaneous pops, checking pointer wrap and correct tags.
- Flush and reset:
  - Flush with 3 entries queued and in_valid high: next cycle out_valid = 0, the concurrent input is dropped and illegal_count is unchanged.
  - Async reset mid-stream: outputs go to reset values without waiting for a clock edge.
- CNT_WIDTH = 2: five illegal accepts leave illegal_count = 3, saturated with no wrap.

Source files
------------

// File: rtl/alu_uop_decoder_if.sv
// rtl/alu_uop_decoder_if.sv - instruction-in / decoded-uop-out handshake bundle
interface alu_uop_decoder_if #(
   parameter int TAG_WIDTH = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [6:0]           in_opcode;
   logic [2:0]           in_funct3;
   logic [6:0]           in_funct7;
   logic [TAG_WIDTH-1:0] in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [3:0]           out_ctrl_op;
   logic [3:0]           out_class;
   logic                 out_is_imm;
   logic                 out_illegal;
   logic [TAG_WIDTH-1:0] out_tag;

   modport master (
      output in_valid, in_opcode, in_funct3, in_funct7, in_tag, out_ready,
      input  in_ready, out_valid, out_ctrl_op, out_class, out_is_imm,
             out_illegal, out_tag
   );

   modport slave (
      input  in_valid, in_opcode, in_funct3, in_funct7, in_tag, out_ready,
      output in_ready, out_valid, out_ctrl_op, out_class, out_is_imm,
             out_illegal, out_tag
   );
endinterface

// File: rtl/alu_uop_decoder.sv
// rtl/alu_uop_decoder.sv - RV32I OP/OP-IMM ALU decode into a DEPTH-entry uop FIFO
module alu_uop_decoder #(
   parameter int TAG_WIDTH = 4,
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   alu_uop_decoder_if.slave     bus,
   output logic [CNT_WIDTH-1:0] illegal_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = TAG_WIDTH + 10;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [3:0] OP_NONE = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2,
                          OP_AND = 4'd3, OP_OR = 4'd4, OP_XOR = 4'd5,
                          OP_SLL = 4'd6, OP_SRL = 4'd7, OP_SRA = 4'd8,
                          OP_SLT = 4'd9, OP_SLTU = 4'd10;

   logic [EW-1:0]        r_mem [DEPTH];
   logic [PW-1:0]        r_wptr, r_rptr;
   logic [CW-1:0]        r_count;
   logic [CNT_WIDTH-1:0] r_illegal_count;

   logic [3:0]    w_op, w_class;
   logic          w_imm, w_ill;
   logic          w_in_ready, w_out_valid, w_push, w_pop;
   logic [EW-1:0] w_entry, w_head;

   always_comb begin
      w_op  = OP_NONE;
      w_imm = 1'b0;
      w_ill = 1'b1;
      case (bus.in_opcode)
         7'b0110011: begin
            if (bus.in_funct7 == 7'b0000000) begin
               w_ill = 1'b0;
               case (bus.in_funct3)
                  3'b000:  w_op = OP_ADD;
                  3'b001:  w_op = OP_SLL;
                  3'b010:  w_op = OP_SLT;
                  3'b011:  w_op = OP_SLTU;
                  3'b100:  w_op = OP_XOR;
                  3'b101:  w_op = OP_SRL;
                  3'b110:  w_op = OP_OR;
                  default: w_op = OP_AND;
               endcase
            end else if (bus.in_funct7 == 7'b0100000) begin
               if (bus.in_funct3 == 3'b000) begin
                  w_op  = OP_SUB;
                  w_ill = 1'b0;
               end else if (bus.in_funct3 == 3'b101) begin
                  w_op  = OP_SRA;
                  w_ill = 1'b0;
               end
            end
         end
         7'b0010011: begin
            w_imm = 1'b1;
            w_ill = 1'b0;
            case (bus.in_funct3)
               3'b000: w_op = OP_ADD;
               3'b010: w_op = OP_SLT;
               3'b011: w_op = OP_SLTU;
               3'b100: w_op = OP_XOR;
               3'b110: w_op = OP_OR;
               3'b111: w_op = OP_AND;
               3'b001: begin
                  if (bus.in_funct7 == 7'b0000000) w_op = OP_SLL;
                  else                             w_ill = 1'b1;
               end
               default: begin
                  if (bus.in_funct7 == 7'b0000000)      w_op = OP_SRL;
                  else if (bus.in_funct7 == 7'b0100000) w_op = OP_SRA;
                  else                                  w_ill = 1'b1;
               end
            endcase
         end
         default: ;
      endcase
      // Illegal entries must carry all-zero decode fields.
      if (w_ill) begin
         w_op  = OP_NONE;
         w_imm = 1'b0;
      end
   end

   always_comb begin
      w_class = 4'b0000;
      case (w_op)
         OP_ADD, OP_SUB:         w_class = 4'b0001;
         OP_AND, OP_OR, OP_XOR:  w_class = 4'b0010;
         OP_SLL, OP_SRL, OP_SRA: w_class = 4'b0100;
         OP_SLT, OP_SLTU:        w_class = 4'b1000;
         default:                w_class = 4'b0000;
      endcase
   end

   assign w_in_ready  = (r_count != FULL);
   assign w_out_valid = (r_count != '0);
   assign w_push      = bus.in_valid && w_in_ready && !flush;
   assign w_pop       = w_out_valid && bus.out_ready && !flush;
   assign w_entry     = {w_ill, w_imm, w_class, w_op, bus.in_tag};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr          <= '0;
         r_rptr          <= '0;
         r_count         <= '0;
         r_illegal_count <= '0;
      end else begin
         if (w_push && w_ill && (r_illegal_count != '1))
            r_illegal_count <= r_illegal_count + CNT_WIDTH'(1);
         if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_entry;
   end

   // Storage is never reset; an empty FIFO masks the head to zero instead.
   assign w_head = w_out_valid ? r_mem[r_rptr] : '0;

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = w_out_valid;
   assign bus.out_tag     = w_head[TAG_WIDTH-1:0];
   assign bus.out_ctrl_op = w_head[TAG_WIDTH+3:TAG_WIDTH];
   assign bus.out_class   = w_head[TAG_WIDTH+7:TAG_WIDTH+4];
   assign bus.out_is_imm  = w_head[TAG_WIDTH+8];
   assign bus.out_illegal = w_head[TAG_WIDTH+9];
   assign illegal_count   = r_illegal_count;
endmodule
